// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: ALU forwarding, load-use stall, branch flush,
// and a dmem-wait FSM with a sticky timeout plus saturating stall/flush perf counters.
module hazard_ctrl_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_timeout,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WCW     = (WCW_RAW < 1) ? 1 : WCW_RAW;
  localparam int LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic lw_stall;
  logic mem_stall;

  // MEM result is younger than WB, so it takes priority; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
  end

  always_comb begin
    lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mem_stall = (MemReqM && !MemReadyM) || (state_q == ERROR);

    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      // Freeze the whole pipe; branch and load-use are re-evaluated once dmem releases.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall && !PCSrcE;
      StallD = lw_stall && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          if (TIMEOUT_CYCLES == 1) begin
            state_d       = ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WCW'(1);
          end
        end
      end
      WAIT: begin
        if (MemReadyM || !MemReqM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == WCW'(LAST))) begin
          state_d       = ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (StallF && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (FlushE && (flush_count_q != {CNT_W{1'b1}}))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz_state     = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: vector table for combinational paths, sequences for FSM/counters.
module tb_hazard_ctrl_unit;

  localparam int T  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE, hz_state;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl_unit #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .mem_timeout(mem_timeout), .hz_state(hz_state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pc;
    logic [4:0] rdm, rdw;
    logic       rwm, rww, mreq, mrdy;
    logic [1:0] fa, fb;
    logic [6:0] ctl; // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [6:0] ctl_now();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic set_load_use();
    idle_inputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
  endtask

  initial begin
    //                rs1d rs2d rs1e rs2e rde rsrc  pc rdm rdw rwm rww mreq mrdy fa     fb     ctl
    vecs[0]  = '{0, 0, 5,  0,  0, 2'b00, 0, 5,  5,  1, 1, 0, 0, 2'b10, 2'b00, 7'b0000000};
    vecs[1]  = '{0, 0, 5,  0,  0, 2'b00, 0, 0,  5,  1, 1, 0, 0, 2'b01, 2'b00, 7'b0000000};
    vecs[2]  = '{0, 0, 5,  0,  0, 2'b00, 0, 0,  5,  1, 0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[3]  = '{0, 0, 3,  9,  0, 2'b00, 0, 9,  9,  0, 1, 0, 0, 2'b00, 2'b01, 7'b0000000};
    vecs[4]  = '{0, 0, 12, 12, 0, 2'b00, 0, 12, 12, 1, 1, 0, 0, 2'b10, 2'b10, 7'b0000000};
    vecs[5]  = '{0, 0, 0,  0,  0, 2'b00, 0, 0,  0,  1, 1, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[6]  = '{0, 7, 0,  0,  7, 2'b01, 0, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b1100010};
    vecs[7]  = '{0, 7, 0,  0,  0, 2'b01, 0, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[8]  = '{7, 0, 0,  0,  7, 2'b00, 0, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[9]  = '{7, 0, 0,  0,  7, 2'b01, 0, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b1100010};
    vecs[10] = '{0, 7, 0,  0,  7, 2'b01, 1, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b0000110};
    vecs[11] = '{0, 0, 0,  0,  0, 2'b00, 1, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b0000110};
    vecs[12] = '{0, 0, 4,  0,  0, 2'b00, 0, 0,  4,  0, 1, 1, 1, 2'b01, 2'b00, 7'b0000000};
    vecs[13] = '{7, 0, 0,  0,  7, 2'b10, 0, 0,  0,  0, 0, 0, 0, 2'b00, 2'b00, 7'b0000000};
    vecs[14] = '{0, 0, 6,  6,  0, 2'b00, 0, 6,  6,  1, 0, 0, 0, 2'b10, 2'b10, 7'b0000000};

    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("reset_state", 32'(hz_state), 32'd0);
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pc;
      RdM = vecs[i].rdm; RdW = vecs[i].rdw; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      MemReqM = vecs[i].mreq; MemReadyM = vecs[i].mrdy;
      #1;
      check($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(vecs[i].fa));
      check($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(vecs[i].fb));
      check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      @(negedge clk);
    end

    // One load-use cycle bumps both counters by one.
    do_reset();
    set_load_use();
    tick();
    check("lu_flush_cnt", 32'(flush_count), 32'd1);
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // Dmem wait of 3 cycles with a branch pending during the wait.
    do_reset();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("wait%0d_ctl", c), 32'(ctl_now()), 32'b1111001);
      check($sformatf("wait%0d_state", c), 32'(hz_state), (c == 0) ? 32'd0 : 32'd1);
      tick();
    end
    MemReadyM = 1; PCSrcE = 0;
    #1;
    check("wait_release_ctl", 32'(ctl_now()), 32'b0000000);
    tick();
    MemReqM = 0; MemReadyM = 0;
    check("wait_end_state", 32'(hz_state), 32'd0);
    check("wait_stall_cnt", 32'(stall_cycles), 32'd3);
    check("wait_flush_cnt", 32'(flush_count), 32'd0);

    // Timeout after 8 consecutive stalled edges.
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int c = 1; c <= T; c++) begin
      tick();
      if (c == T - 1) begin
        check("to_pre_state", 32'(hz_state), 32'd1);
        check("to_pre_flag", 32'(mem_timeout), 32'd0);
      end
    end
    check("to_state", 32'(hz_state), 32'd2);
    check("to_flag", 32'(mem_timeout), 32'd1);
    check("to_stall_cnt", 32'(stall_cycles), 32'd8);
    MemReqM = 0; PCSrcE = 1;
    tick();
    check("err_hold_state", 32'(hz_state), 32'd2);
    check("err_hold_ctl", 32'(ctl_now()), 32'b1111001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(hz_state), 32'd0);
    check("async_rst_flag", 32'(mem_timeout), 32'd0);
    check("async_rst_cnt", 32'(stall_cycles), 32'd0);
    rst_n = 1'b1;
    PCSrcE = 0;

    // Ready arriving on the 8th stalled cycle beats the timeout.
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int c = 1; c < T; c++) tick();
    MemReadyM = 1;
    tick();
    check("ready_last_state", 32'(hz_state), 32'd0);
    check("ready_last_flag", 32'(mem_timeout), 32'd0);
    check("ready_last_cnt", 32'(stall_cycles), 32'd7);
    MemReqM = 0; MemReadyM = 0;

    // Counter saturation at 2^4-1.
    do_reset();
    set_load_use();
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) check("sat14_stall", 32'(stall_cycles), 32'd14);
      if (c == 15) check("sat15_stall", 32'(stall_cycles), 32'd15);
    end
    check("sat20_stall", 32'(stall_cycles), 32'd15);
    check("sat20_flush", 32'(flush_count), 32'd15);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
